conv_output_streamer: RTL

CONV_OUTPUT_STREAMER -- requirements
Module: conv_output_streamer

---
 rtl/conv_output_streamer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_output_streamer.sv
// conv_output_streamer
//   Captures a flat OUT_H x OUT_W convolution result on a start pulse and
//   streams it out one word per transfer. The order is descending: word N-1
//   comes first and word 0 comes last. The handshake is valid/ready, and the
//   output carries row and frame markers.
//
//   Optional feature: define CONV_STREAM_RELU_EN to zero every word whose
//   sign bit is set. The zeroing is applied on the output path only.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : one-cycle capture request (ignored while busy)
//   outputConv   : flat frame, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data     : streamed word (0 when out_valid is low)
//   out_valid    : out_data holds a valid word
//   out_ready    : consumer accepts the current word
//   out_last_row : current word closes a row of OUT_W words
//   out_last     : current word is word index 0 (end of frame)
//   busy         : a captured frame is still being sent
//   done         : one-cycle pulse after the final transfer
module conv_output_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_H      = 28,
   parameter int OUT_W      = 28
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [OUT_H*OUT_W*DATA_WIDTH-1:0] outputConv,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last_row,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done
);

   localparam int N     = OUT_H * OUT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int ROW_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(N - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_W - 1);

   typedef enum logic {
      S_IDLE,
      S_STREAM
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [N*DATA_WIDTH-1:0] r_frame;
   logic [IDX_W-1:0]        r_idx;
   logic [ROW_W-1:0]        r_row;
   logic                    r_done;

   logic                    w_capture;
   logic                    w_xfer;
   logic                    w_final;
   logic [DATA_WIDTH-1:0]   w_word;
   logic [DATA_WIDTH-1:0]   w_out_word;

   assign w_capture = (r_state == S_IDLE) && start;
   assign w_xfer    = (r_state == S_STREAM) && out_ready;
   assign w_final   = w_xfer && (r_idx == '0);

   // The frame buffer has no reset. Its contents only matter after a capture.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_frame <= outputConv;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_row   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_final;
         if (w_capture) begin
            r_idx <= IDX_FIRST;
            r_row <= '0;
         end else if (w_xfer) begin
            // The index saturates at 0. It is reloaded only by the next capture.
            if (r_idx != '0) begin
               r_idx <= r_idx - 1'b1;
            end
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
         end
      end
   end

   always_comb begin
      w_word = r_frame[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef CONV_STREAM_RELU_EN
      w_out_word = w_word[DATA_WIDTH-1] ? '0 : w_word;
`else
      w_out_word = w_word;
`endif
   end

   always_comb begin
      w_state_nxt  = r_state;
      out_valid    = 1'b0;
      busy         = 1'b0;
      out_data     = '0;
      out_last_row = 1'b0;
      out_last     = 1'b0;
      done         = r_done;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            out_valid    = 1'b1;
            busy         = 1'b1;
            out_data     = w_out_word;
            out_last_row = (r_row == ROW_LAST);
            out_last     = (r_idx == '0);
            if (w_final) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
